// File: rtl/fp_mul_arbiter.sv
// Shares one IEEE-754 single-precision multiplier between two valid/ready requesters.
// Round-robin grant, registered operands/result, a single operation in flight.
module fp_mul_arbiter #(
  parameter int MUL_LAT = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  output logic        rsp0_valid,
  input  logic        rsp0_ready,
  output logic [31:0] rsp0_result,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  output logic        rsp1_valid,
  input  logic        rsp1_ready,
  output logic [31:0] rsp1_result,
  output logic [31:0] mul_a,
  output logic [31:0] mul_b,
  input  logic [31:0] mul_result,
  output logic        busy
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  generate
    if (MUL_LAT < 1 || MUL_LAT > 15) begin : g_bad_lat
      $error("fp_mul_arbiter: MUL_LAT must be within 1..15");
    end
  endgenerate

  logic [1:0]  state;
  logic [3:0]  cnt;
  logic        owner;
  logic        last_grant;
  logic [31:0] result;

  logic grant;
  logic accept;
  logic owner_ready;

  // Both valid: the requester not served last time wins; otherwise the lone valid one.
  always_comb begin
    grant = 1'b0;
    if (req0_valid && req1_valid) grant = ~last_grant;
    else if (req1_valid)          grant = 1'b1;
  end

  // Ready is gated by rst_n so nothing is offered while reset is held.
  assign accept      = rst_n && (state == IDLE) && (req0_valid || req1_valid);
  assign req0_ready  = accept && !grant;
  assign req1_ready  = accept && grant;
  assign owner_ready = owner ? rsp1_ready : rsp0_ready;

  // NOTE: every register here uses non-blocking assignment so all updates take
  // effect together at the edge, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= 4'd0;
      owner      <= 1'b0;
      last_grant <= 1'b1;
      mul_a      <= 32'd0;
      mul_b      <= 32'd0;
      result     <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            mul_a      <= grant ? req1_a : req0_a;
            mul_b      <= grant ? req1_b : req0_b;
            owner      <= grant;
            last_grant <= grant;
            cnt        <= 4'(MUL_LAT);
            state      <= WAIT;
          end
        end
        WAIT: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) begin
            result <= mul_result;
            state  <= RESP;
          end
        end
        RESP: begin
          if (owner_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // The result register drives both channels; valid alone says whose product it is.
  assign rsp0_valid  = (state == RESP) && !owner;
  assign rsp1_valid  = (state == RESP) && owner;
  assign rsp0_result = result;
  assign rsp1_result = result;
  assign busy        = (state != IDLE);

endmodule
